// File: rtl/multi_memory_ctrl.sv
// Multi-cycle data memory with req/ready handshake, programmable wait states and held read data.
// Define MULTI_MEM_BYTE_WE_EN to honour wstrb byte lanes on writes; otherwise writes are full-word.
module multi_memory_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clka,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                busy,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Depth    = 2 ** ADDR_W;

  if (WAIT_CYCLES > 15) begin : g_wait_check
    $error("multi_memory_ctrl: WAIT_CYCLES=%0d exceeds the 4-bit counter", WAIT_CYCLES);
  end

  typedef enum logic {StIdle, StWait} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ready_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                accept;
  logic                commit;

  logic [DATA_W-1:0]   mem [Depth];

  assign accept = (state_q == StIdle) && req;
  assign commit = (state_q == StWait) && (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StWait;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= commit;
      if (commit && !we_q) begin
        rdata_q <= mem[addr_q];
      end
    end
  end

  // Request fields are captured once at acceptance and held for the whole transaction.
  always_ff @(posedge clka) begin
    if (accept) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

`ifdef MULTI_MEM_BYTE_WE_EN
  logic [NumBytes-1:0] wstrb_q;

  always_ff @(posedge clka) begin
    if (accept) begin
      wstrb_q <= wstrb;
    end
  end

  always_ff @(posedge clka) begin
    if (!rst && commit && we_q) begin
      for (int i = 0; i < NumBytes; i++) begin
        if (wstrb_q[i]) begin
          mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb;

  always_ff @(posedge clka) begin
    if (!rst && commit && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end
`endif

  assign busy  = (state_q == StWait);
  assign ready = ready_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_multi_memory_ctrl.sv
// Directed self-checking bench for multi_memory_ctrl (WAIT_CYCLES=2, DATA_W=32, ADDR_W=10).
module tb_multi_memory_ctrl;

  localparam int unsigned WaitCycles = 2;
  localparam int          Lat        = WaitCycles + 1;  // accept edge to ready cycle
  localparam int          Period     = WaitCycles + 2;  // ready-to-ready with req held

  logic        clka;
  logic        rst;
  logic        req;
  logic        we;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;

  int vectors     = 0;
  int miscompares = 0;

  multi_memory_ctrl #(
    .DATA_W     (32),
    .ADDR_W     (10),
    .WAIT_CYCLES(WaitCycles)
  ) dut (
    .clka (clka),
    .rst  (rst),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .wstrb(wstrb),
    .busy (busy),
    .ready(ready),
    .rdata(rdata)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  // Issues one access from IDLE, drives junk while busy, returns at the ready cycle.
  task automatic do_access(input logic w, input logic [9:0] a, input logic [31:0] d,
                           input logic [3:0] s, output int lat, output int bcyc,
                           output logic [31:0] rd);
    req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    step();
    lat = 0;
    bcyc = 0;
    req = 1'b1; we = 1'b1; addr = 10'h3FF; wdata = 32'hBAD0BAD0; wstrb = 4'hF;
    while (ready !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) bcyc++;
      step();
      lat++;
    end
    req = 1'b0; we = 1'b0;
    rd = rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_busy cycle %0d: got %b, expected 0", i, busy);
      end
      vectors++;
      if (ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_ready cycle %0d: got %b, expected 0", i, ready);
      end
      vectors++;
      if (rdata !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_rdata cycle %0d: got %h, expected 00000000", i, rdata);
      end
    end
  endtask

  task automatic test_write_read();
    int lat, bcyc;
    logic [31:0] rd;
    do_access(1'b1, 10'h005, 32'hDEADBEEF, 4'hF, lat, bcyc, rd);
    vectors++;
    if (lat !== Lat) begin
      miscompares++;
      $display("FAIL wr_latency: got %0d, expected %0d", lat, Lat);
    end
    vectors++;
    if (bcyc !== Lat) begin
      miscompares++;
      $display("FAIL wr_busy_cycles: got %0d, expected %0d", bcyc, Lat);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_busy_in_ready: got %b, expected 0", busy);
    end
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL wr_rdata_held: got %h, expected 00000000", rd);
    end
    step();
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_one_cycle: got %b, expected 0", ready);
    end
    do_access(1'b0, 10'h005, 32'h0, 4'h0, lat, bcyc, rd);
    vectors++;
    if (lat !== Lat) begin
      miscompares++;
      $display("FAIL rd_latency: got %0d, expected %0d", lat, Lat);
    end
    vectors++;
    if (bcyc !== Lat) begin
      miscompares++;
      $display("FAIL rd_busy_cycles: got %0d, expected %0d", bcyc, Lat);
    end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL rd_data: got %h, expected deadbeef", rd);
    end
    step();
  endtask

  task automatic test_rdata_hold();
    int lat, bcyc;
    logic [31:0] rd;
    do_access(1'b0, 10'h005, 32'h0, 4'h0, lat, bcyc, rd);
    do_access(1'b1, 10'h006, 32'h12345678, 4'hF, lat, bcyc, rd);
    vectors++;
    if (rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL hold_after_write: got %h, expected deadbeef", rd);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (rdata !== 32'hDEADBEEF) begin
        miscompares++;
        $display("FAIL hold_idle cycle %0d: got %h, expected deadbeef", i, rdata);
      end
    end
    do_access(1'b0, 10'h006, 32'h0, 4'h0, lat, bcyc, rd);
    vectors++;
    if (rd !== 32'h12345678) begin
      miscompares++;
      $display("FAIL hold_readback: got %h, expected 12345678", rd);
    end
    step();
  endtask

  task automatic test_byte_strobe();
    int lat, bcyc;
    logic [31:0] rd, exp;
`ifdef MULTI_MEM_BYTE_WE_EN
    exp = 32'h11BB11DD;
`else
    exp = 32'hAABBCCDD;
`endif
    do_access(1'b1, 10'h007, 32'h11111111, 4'hF, lat, bcyc, rd);
    do_access(1'b1, 10'h007, 32'hAABBCCDD, 4'b0101, lat, bcyc, rd);
    do_access(1'b0, 10'h007, 32'h0, 4'h0, lat, bcyc, rd);
    vectors++;
    if (rd !== exp) begin
      miscompares++;
      $display("FAIL byte_strobe: got %h, expected %h", rd, exp);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat, bcyc, k, last, cyc, extra;
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      do_access(1'b1, 10'(i), 32'hA0 + 32'(i), 4'hF, lat, bcyc, rd);
    end
    step();
    k = 0; last = 0; cyc = 0;
    req = 1'b1; we = 1'b0; addr = 10'h000; wdata = 32'hFFFF0000;
    while (k < 4 && cyc < 40) begin
      step();
      cyc++;
      if (ready === 1'b1) begin
        vectors++;
        if (rdata !== 32'hA0 + 32'(k)) begin
          miscompares++;
          $display("FAIL b2b_rdata %0d: got %h, expected %h", k, rdata, 32'hA0 + 32'(k));
        end
        if (k > 0) begin
          vectors++;
          if (cyc - last !== Period) begin
            miscompares++;
            $display("FAIL b2b_spacing %0d: got %0d, expected %0d", k, cyc - last, Period);
          end
        end
        last = cyc;
        k++;
        addr = 10'(k);
      end
      if (k == 4) req = 1'b0;
      // Junk writes to the next read address while busy must be ignored.
      we = (busy === 1'b1);
      wdata = 32'hFFFF0000 | 32'(k);
    end
    req = 1'b0; we = 1'b0;
    vectors++;
    if (k !== 4) begin
      miscompares++;
      $display("FAIL b2b_pulses: got %0d, expected 4", k);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ready === 1'b1) extra++;
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++;
      $display("FAIL b2b_extra_pulses: got %0d, expected 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int lat, bcyc, seen;
    logic [31:0] rd;
    do_access(1'b1, 10'h010, 32'h01020304, 4'hF, lat, bcyc, rd);
    step();
    req = 1'b1; we = 1'b1; addr = 10'h010; wdata = 32'hCAFEF00D; wstrb = 4'hF;
    step();
    req = 1'b0; we = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_busy: got %b, expected 0", busy);
    end
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_rdata: got %h, expected 00000000", rdata);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (ready === 1'b1) seen++;
      step();
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL abort_ready: got %0d pulses, expected 0", seen);
    end
    do_access(1'b0, 10'h010, 32'h0, 4'h0, lat, bcyc, rd);
    vectors++;
    if (rd !== 32'h01020304) begin
      miscompares++;
      $display("FAIL abort_mem: got %h, expected 01020304", rd);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_rdata_hold();
    test_byte_strobe();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
